// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master
// Description : Single-outstanding AXI4-Lite initiator. It converts a simple
//               command/response stream into AXI4-Lite read and write
//               transactions and counts non-OKAY responses in a saturating
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int ERR_CNT_BW_p  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    // command stream
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_we,
    input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
    input  logic [31:0]              i_cmd_wdata,
    // response stream
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_we,
    output logic [31:0]              o_rsp_rdata,
    output logic [1:0]               o_rsp_resp,
    // status
    output logic                     o_busy,
    output logic [ERR_CNT_BW_p-1:0]  o_err_cnt,
    // AXI4-Lite write channels
    output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
    output logic                     o_axi_awvalid,
    input  logic                     i_axi_awready,
    output logic [31:0]              o_axi_wdata,
    output logic                     o_axi_wvalid,
    input  logic                     i_axi_wready,
    input  logic [1:0]               i_axi_bresp,
    input  logic                     i_axi_bvalid,
    output logic                     o_axi_bready,
    // AXI4-Lite read channels
    output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
    output logic                     o_axi_arvalid,
    input  logic                     i_axi_arready,
    input  logic [31:0]              i_axi_rdata,
    input  logic [1:0]               i_axi_rresp,
    input  logic                     i_axi_rvalid,
    output logic                     o_axi_rready
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_REQ  = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_REQ  = 3'd3;
    localparam logic [2:0] c_RD_DATA = 3'd4;
    localparam logic [2:0] c_RSP     = 3'd5;

    logic [2:0]               r_state_q,     w_state_d;
    logic [AXI_ADDR_BW_p-1:0] r_addr_q,      w_addr_d;
    logic [31:0]              r_wdata_q,     w_wdata_d;
    logic                     r_awvalid_q,   w_awvalid_d;
    logic                     r_wvalid_q,    w_wvalid_d;
    logic                     r_bready_q,    w_bready_d;
    logic                     r_arvalid_q,   w_arvalid_d;
    logic                     r_rready_q,    w_rready_d;
    logic                     r_rsp_valid_q, w_rsp_valid_d;
    logic                     r_rsp_we_q,    w_rsp_we_d;
    logic [31:0]              r_rsp_rdata_q, w_rsp_rdata_d;
    logic [1:0]               r_rsp_resp_q,  w_rsp_resp_d;
    logic [ERR_CNT_BW_p-1:0]  r_err_cnt_q,   w_err_cnt_d;
    logic                     w_capture;
    logic [1:0]               w_cap_resp;

    // Next-state and datapath decode for the transaction sequencer
    always_comb begin
        w_state_d     = r_state_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_awvalid_d   = r_awvalid_q;
        w_wvalid_d    = r_wvalid_q;
        w_bready_d    = r_bready_q;
        w_arvalid_d   = r_arvalid_q;
        w_rready_d    = r_rready_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_we_d    = r_rsp_we_q;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_resp_d  = r_rsp_resp_q;
        w_capture     = 1'b0;
        w_cap_resp    = 2'b00;

        case (r_state_q)
            c_IDLE: begin
                if (i_cmd_valid) begin
                    w_addr_d  = i_cmd_addr;
                    w_wdata_d = i_cmd_wdata;
                    if (i_cmd_we) begin
                        w_awvalid_d = 1'b1;
                        w_wvalid_d  = 1'b1;
                        w_state_d   = c_WR_REQ;
                    end else begin
                        w_arvalid_d = 1'b1;
                        w_state_d   = c_RD_REQ;
                    end
                end
            end
            c_WR_REQ: begin
                // AW and W complete independently; move on once both are done
                if (i_axi_awready) w_awvalid_d = 1'b0;
                if (i_axi_wready)  w_wvalid_d  = 1'b0;
                if (!w_awvalid_d && !w_wvalid_d) begin
                    w_bready_d = 1'b1;
                    w_state_d  = c_WR_RESP;
                end
            end
            c_WR_RESP: begin
                if (r_bready_q && i_axi_bvalid) begin
                    w_capture     = 1'b1;
                    w_cap_resp    = i_axi_bresp;
                    w_rsp_resp_d  = i_axi_bresp;
                    w_rsp_rdata_d = 32'd0;
                    w_rsp_we_d    = 1'b1;
                    w_bready_d    = 1'b0;
                    w_rsp_valid_d = 1'b1;
                    w_state_d     = c_RSP;
                end
            end
            c_RD_REQ: begin
                if (r_arvalid_q && i_axi_arready) begin
                    w_arvalid_d = 1'b0;
                    w_rready_d  = 1'b1;
                    w_state_d   = c_RD_DATA;
                end
            end
            c_RD_DATA: begin
                if (r_rready_q && i_axi_rvalid) begin
                    w_capture     = 1'b1;
                    w_cap_resp    = i_axi_rresp;
                    w_rsp_resp_d  = i_axi_rresp;
                    w_rsp_rdata_d = i_axi_rdata;
                    w_rsp_we_d    = 1'b0;
                    w_rready_d    = 1'b0;
                    w_rsp_valid_d = 1'b1;
                    w_state_d     = c_RSP;
                end
            end
            c_RSP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    w_state_d     = c_IDLE;
                end
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // Saturating count of non-OKAY responses, bumped at the capture cycle
    always_comb begin
        w_err_cnt_d = r_err_cnt_q;
        if (w_capture && (w_cap_resp != 2'b00) && (r_err_cnt_q != '1)) begin
            w_err_cnt_d = r_err_cnt_q + ERR_CNT_BW_p'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_IDLE;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_awvalid_q   <= 1'b0;
            r_wvalid_q    <= 1'b0;
            r_bready_q    <= 1'b0;
            r_arvalid_q   <= 1'b0;
            r_rready_q    <= 1'b0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_we_q    <= 1'b0;
            r_rsp_rdata_q <= '0;
            r_rsp_resp_q  <= '0;
            r_err_cnt_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_awvalid_q   <= w_awvalid_d;
            r_wvalid_q    <= w_wvalid_d;
            r_bready_q    <= w_bready_d;
            r_arvalid_q   <= w_arvalid_d;
            r_rready_q    <= w_rready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_we_q    <= w_rsp_we_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_resp_q  <= w_rsp_resp_d;
            r_err_cnt_q   <= w_err_cnt_d;
        end
    end

    // cmd_ready is masked by reset so nothing looks acceptable mid-reset
    assign o_cmd_ready   = (r_state_q == c_IDLE) && !rst;
    assign o_busy        = (r_state_q != c_IDLE);

    assign o_rsp_valid   = r_rsp_valid_q;
    assign o_rsp_we      = r_rsp_we_q;
    assign o_rsp_rdata   = r_rsp_rdata_q;
    assign o_rsp_resp    = r_rsp_resp_q;
    assign o_err_cnt     = r_err_cnt_q;

    assign o_axi_awaddr  = r_addr_q;
    assign o_axi_awvalid = r_awvalid_q;
    assign o_axi_wdata   = r_wdata_q;
    assign o_axi_wvalid  = r_wvalid_q;
    assign o_axi_bready  = r_bready_q;
    assign o_axi_araddr  = r_addr_q;
    assign o_axi_arvalid = r_arvalid_q;
    assign o_axi_rready  = r_rready_q;

endmodule
`default_nettype wire

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command/response stream into AXI4-Lite read and write transactions.
- Used in the timer/counter subsystem as the bus driver for register programming. Sources include bring-up sequencers, self-test logic and the bench's reference driver. It connects directly to the slave AXI port of the timer/counter top.
- Signal set matches the slave side exactly: 32-bit data, no WSTRB, no PROT.

Parameters:
- AXI_ADDR_BW_p, 12, width of AXI read/write address and command address.
- ERR_CNT_BW_p, 8, width of saturating error-response counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- i_cmd_valid  input  1  command present
- o_cmd_ready  output  1  master can accept command
- i_cmd_we  input  1  1 = write, 0 = read
- i_cmd_addr  input  AXI_ADDR_BW_p  transaction address
- i_cmd_wdata  input  32  write data (ignored for reads)
- o_rsp_valid  output  1  response present
- i_rsp_ready  input  1  consumer accepts response
- o_rsp_we  output  1  echo of command type
- o_rsp_rdata  output  32  read data; 0 for writes
- o_rsp_resp  output  2  BRESP/RRESP captured from slave
- o_busy  output  1  high whenever state != IDLE
- o_err_cnt  output  ERR_CNT_BW_p  count of non-OKAY responses, saturating
- o_axi_awaddr  output  AXI_ADDR_BW_p  write address
- o_axi_awvalid  output  1
- i_axi_awready  input  1
- o_axi_wdata  output  32
- o_axi_wvalid  output  1
- i_axi_wready  input  1
- i_axi_bresp  input  2
- i_axi_bvalid  input  1
- o_axi_bready  output  1
- o_axi_araddr  output  AXI_ADDR_BW_p
- o_axi_arvalid  output  1
- i_axi_arready  input  1
- i_axi_rdata  input  32
- i_axi_rresp  input  2
- i_axi_rvalid  input  1
- o_axi_rready  output  1

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE. All o_axi_*valid, o_axi_bready, o_axi_rready, o_rsp_valid, o_busy = 0. All address, data and response registers = 0. o_err_cnt = 0. o_cmd_ready = 0 during the reset cycle.
- Reset mid-transaction abandons everything immediately; no completion is produced. Cleanliness of the slave side is the system's concern.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- All outputs are registered except o_cmd_ready and o_busy, which are decoded from state.
- IDLE:
  - o_cmd_ready=1.
  - Accept on i_cmd_valid&&o_cmd_ready; latch we, addr and wdata.
  - we=1 -> WR_REQ with awvalid=wvalid=1 from the next cycle.
  - we=0 -> RD_REQ with arvalid=1 from the next cycle.
- WR_REQ:
  - AW and W channels are independent.
  - awvalid drops the cycle after awvalid&&awready; wvalid drops the cycle after wvalid&&wready.
  - Both handshakes in the same cycle, or in either order, are legal.
  - Address and data stay stable while their valid is high.
  - Once both have completed -> WR_RESP, with bready=1 from that next cycle.
- WR_RESP:
  - On bvalid&&bready: capture bresp, set rsp_rdata=0, rsp_we=1, bready=0 -> RSP.
- RD_REQ:
  - On arvalid&&arready: arvalid=0, rready=1 -> RD_DATA.
- RD_DATA:
  - On rvalid&&rready: capture rdata/rresp, rsp_we=0, rready=0 -> RSP.
- RSP:
  - o_rsp_valid=1, response fields held stable until i_rsp_ready.
  - On o_rsp_valid&&i_rsp_ready: o_rsp_valid=0 -> IDLE. A new command can be accepted the following cycle (no same-cycle turnaround).
- Error counter:
  - Increments by 1 at the capture cycle when the captured resp != 2'b00.
  - Holds at all-ones (255 by default); never wraps.
- Minimum latency with a zero-wait slave (ready/valid immediate):
  - Write: cmd accepted T; AW/W handshakes T+1; bvalid sampled T+2; o_rsp_valid T+3.
  - Read: cmd accepted T; AR handshake T+1; R handshake T+2; o_rsp_valid T+3.
- No timeouts; the block waits indefinitely on each channel.
- Inputs i_axi_* are don't-care outside their wait state. A bvalid or rvalid arriving while ready=0 is not consumed.

Test Plan:
- Write with zero-wait slave: cmd we=1, addr=0x004, wdata=0xDEADBEEF at T -> awvalid/wvalid at T+1 carry 0x004/0xDEADBEEF; bresp=00 -> o_rsp_valid at T+3, resp=00, rdata=0, o_err_cnt=0.
- Skewed write: wready at T+1, awready at T+4, bvalid at T+7 -> wvalid low from T+2, awvalid high until T+4 with addr stable, bready high from T+5, response at T+8.
- Read with wait states: addr=0x010, arready at T+3, rvalid at T+6 with rdata=0x12345678 -> rready only from T+4, o_rsp_rdata=0x12345678, o_rsp_we=0.
- Response backpressure: i_rsp_ready low for 5 cycles -> o_rsp_valid and fields stable, o_cmd_ready=0, o_busy=1; after the accept, o_cmd_ready=1 next cycle.
- Error saturation: 300 writes each with bresp=2'b10 -> o_err_cnt reaches 255 and stays there; each response shows resp=10.
- Reset mid-read (rst asserted in RD_DATA) -> next cycle all valids/readies 0, state IDLE, o_err_cnt=0, no o_rsp_valid.
